// File: rtl/noc_rr_pkt_arbiter.sv
// Round-robin arbiter: grants one of NUM_PORTS deframer packets into a registered output stage with its XY route.
// Latency 1 cycle from i_ready handshake to o_valid; while o_valid && !o_ready the output holds and all i_ready stay low.
module noc_rr_pkt_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int COORD_W   = 4,
    parameter int PAYLOAD_W = 32,
    parameter int LOCAL_X   = 0,
    parameter int LOCAL_Y   = 0,
    localparam int PKT_W    = 2*COORD_W + PAYLOAD_W,
    localparam int IDX_W    = $clog2(NUM_PORTS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_PORTS-1:0]       i_valid,
    input  logic [NUM_PORTS*PKT_W-1:0] i_pkt,
    output logic [NUM_PORTS-1:0]       i_ready,
    output logic                       o_valid,
    output logic [PKT_W-1:0]           o_pkt,
    output logic [IDX_W-1:0]           o_src,
    output logic [2:0]                 o_dir,
    input  logic                       o_ready
);

    localparam logic [2:0] DIR_LOCAL = 3'd0;
    localparam logic [2:0] DIR_EAST  = 3'd1;
    localparam logic [2:0] DIR_WEST  = 3'd2;
    localparam logic [2:0] DIR_NORTH = 3'd3;
    localparam logic [2:0] DIR_SOUTH = 3'd4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PKT_W-1:0]   r_pkt;
    logic [IDX_W-1:0]   r_src;
    logic [2:0]         r_dir;
    logic [IDX_W-1:0]   r_ptr;

    logic               w_any_req;
    logic               w_can_load;
    logic               w_load;
    logic               w_gnt_found;
    logic [IDX_W-1:0]   w_scan_idx;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic [PKT_W-1:0]   w_gnt_pkt;
    logic [COORD_W-1:0] w_gnt_x;
    logic [COORD_W-1:0] w_gnt_y;

    // Dimension-order routing: resolve X first, then Y, unsigned compare.
    function automatic logic [2:0] route_dir(input logic [COORD_W-1:0] x,
                                             input logic [COORD_W-1:0] y);
        if (x > COORD_W'(LOCAL_X))
            return DIR_EAST;
        else if (x < COORD_W'(LOCAL_X))
            return DIR_WEST;
        else if (y > COORD_W'(LOCAL_Y))
            return DIR_NORTH;
        else if (y < COORD_W'(LOCAL_Y))
            return DIR_SOUTH;
        else
            return DIR_LOCAL;
    endfunction

    assign w_any_req  = |i_valid;
    assign w_can_load = (r_state == ST_EMPTY) || o_ready;
    assign w_load     = w_can_load && w_any_req && !rst;

    // Scan starts at the pointer; index arithmetic wraps because NUM_PORTS is a power of two.
    always_comb begin
        w_gnt_idx   = '0;
        w_gnt_found = 1'b0;
        w_scan_idx  = r_ptr;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_scan_idx = r_ptr + IDX_W'(k);
            if (!w_gnt_found && i_valid[w_scan_idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_scan_idx;
            end
        end
    end

    assign w_gnt_pkt = i_pkt[w_gnt_idx*PKT_W +: PKT_W];
    assign w_gnt_x   = w_gnt_pkt[PKT_W-1 -: COORD_W];
    assign w_gnt_y   = w_gnt_pkt[PAYLOAD_W +: COORD_W];

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_EMPTY;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        i_ready     = '0;
        if (w_load)
            i_ready[w_gnt_idx] = 1'b1;
        case (r_state)
            ST_EMPTY: if (w_load) w_state_nxt = ST_FULL;
            ST_FULL:  if (o_ready && !w_any_req) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // Data fields are only written on a load, so a plain drain leaves them as they were.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt <= '0;
            r_src <= '0;
            r_dir <= DIR_LOCAL;
            r_ptr <= '0;
        end else if (w_load) begin
            r_pkt <= w_gnt_pkt;
            r_src <= w_gnt_idx;
            r_dir <= route_dir(w_gnt_x, w_gnt_y);
            r_ptr <= w_gnt_idx + IDX_W'(1);
        end
    end

    assign o_valid = (r_state == ST_FULL);
    assign o_pkt   = r_pkt;
    assign o_src   = r_src;
    assign o_dir   = r_dir;

endmodule

// File: tb/tb_noc_rr_pkt_arbiter.sv
// Scoreboard bench for noc_rr_pkt_arbiter with LOCAL=(2,2): directed vectors plus a small random-payload stress.
module tb_noc_rr_pkt_arbiter;

    localparam int NP    = 4;
    localparam int PKT_W = 40;
    localparam logic [2:0] D_LOCAL = 3'd0;
    localparam logic [2:0] D_EAST  = 3'd1;
    localparam logic [2:0] D_WEST  = 3'd2;
    localparam logic [2:0] D_NORTH = 3'd3;
    localparam logic [2:0] D_SOUTH = 3'd4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NP-1:0]         i_valid;
    logic [NP*PKT_W-1:0]   i_pkt;
    logic [NP-1:0]         i_ready;
    logic                  o_valid;
    logic [PKT_W-1:0]      o_pkt;
    logic [1:0]            o_src;
    logic [2:0]            o_dir;
    logic                  o_ready;

    always #5 clk = ~clk;

    noc_rr_pkt_arbiter #(
        .NUM_PORTS(NP), .COORD_W(4), .PAYLOAD_W(32), .LOCAL_X(2), .LOCAL_Y(2)
    ) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_pkt(i_pkt), .i_ready(i_ready),
        .o_valid(o_valid), .o_pkt(o_pkt), .o_src(o_src), .o_dir(o_dir), .o_ready(o_ready)
    );

    typedef logic [PKT_W-1:0] pkt_t;
    typedef pkt_t pkt_q_t[$];
    typedef struct packed {
        pkt_t       pkt;
        logic [1:0] src;
        logic [2:0] dir;
    } exp_t;

    pkt_q_t pq [NP];
    exp_t   exp_q[$];
    exp_t   mon_e;
    int     n_chk  = 0;
    int     n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic pkt_t mk(input int x, input int y, input logic [31:0] pl);
        return {4'(x), 4'(y), pl};
    endfunction

    function automatic logic [2:0] exp_dir(input int x, input int y);
        if (x > 2) return D_EAST;
        if (x < 2) return D_WEST;
        if (y > 2) return D_NORTH;
        if (y < 2) return D_SOUTH;
        return D_LOCAL;
    endfunction

    task automatic send(input int p, input pkt_t pkt, input logic [2:0] dir, input bit expect_out);
        exp_t e;
        pq[p].push_back(pkt);
        if (expect_out) begin
            e.pkt = pkt;
            e.src = 2'(p);
            e.dir = dir;
            exp_q.push_back(e);
        end
    endtask

    // Deframer model: each port presents its queue head until it sees its i_ready handshake.
    initial begin
        logic [NP-1:0] rdy_s;
        pkt_t          dummy;
        i_valid = '0;
        i_pkt   = '0;
        forever begin
            @(negedge clk);
            rdy_s = i_ready;
            @(posedge clk);
            #2;
            for (int p = 0; p < NP; p++) begin
                if (i_valid[p] && rdy_s[p]) begin
                    dummy = pq[p].pop_front();
                    i_valid[p] = 1'b0;
                end
                if (!i_valid[p] && pq[p].size() > 0) begin
                    i_valid[p] = 1'b1;
                    i_pkt[p*PKT_W +: PKT_W] = pq[p][0];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && o_valid && o_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out: got pkt %h src %0d, required no output", o_pkt, o_src);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_pkt", 64'(o_pkt), 64'(mon_e.pkt));
                chk("out_src", 64'(o_src), 64'(mon_e.src));
                chk("out_dir", 64'(o_dir), 64'(mon_e.dir));
            end
        end
    end

    task automatic wait_drain(input int budget);
        int bubbles = 0;
        bit seen = 1'b0;
        for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
            @(negedge clk);
            #1;
            if (o_valid) seen = 1'b1;
            else if (seen) bubbles++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        chk("bubbles", 64'(bubbles), 64'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        int x, y, left;
        rst     = 1'b1;
        o_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_o_pkt",   64'(o_pkt),   64'd0);
        chk("rst_o_src",   64'(o_src),   64'd0);
        chk("rst_o_dir",   64'(o_dir),   64'd0);
        chk("rst_i_ready", 64'(i_ready), 64'd0);
        @(posedge clk); #1;
        rst     = 1'b0;
        o_ready = 1'b1;

        // Single request from port 2, dest (3,2) -> EAST.
        send(2, mk(3, 2, 32'hDEADBEEF), D_EAST, 1'b1);
        @(negedge clk); #1;
        chk("t1_i_ready", 64'(i_ready), 64'b0100);
        @(negedge clk); #1;
        chk("t1_i_ready_pulse", 64'(i_ready), 64'd0);
        wait_drain(20);

        // All four ports, two packets each; ptr=0 after reset.
        pulse_reset();
        for (int k = 0; k < 2; k++) begin
            send(0, mk(0, 2, 32'h2000_0000 + k*16 + 0), D_WEST,  1'b1);
            send(1, mk(1, 2, 32'h2000_0000 + k*16 + 1), D_WEST,  1'b1);
            send(2, mk(2, 2, 32'h2000_0000 + k*16 + 2), D_LOCAL, 1'b1);
            send(3, mk(3, 2, 32'h2000_0000 + k*16 + 3), D_EAST,  1'b1);
        end
        wait_drain(40);

        // Backpressure with ports 1 and 3; ptr=0 so port 1 first.
        @(posedge clk); #1 o_ready = 1'b0;
        send(1, mk(1, 5, 32'h1111_0001), D_WEST,  1'b1);
        send(3, mk(2, 7, 32'h3333_0003), D_NORTH, 1'b1);
        @(negedge clk); #1;
        chk("t3_first_grant", 64'(i_ready), 64'b0010);
        @(posedge clk);
        repeat (5) begin
            @(negedge clk); #1;
            chk("hold_vld",     64'(o_valid), 64'd1);
            chk("hold_pkt",     64'(o_pkt),   64'(mk(1, 5, 32'h1111_0001)));
            chk("hold_src",     64'(o_src),   64'd1);
            chk("hold_i_ready", 64'(i_ready), 64'd0);
        end
        @(posedge clk); #1 o_ready = 1'b1;
        @(negedge clk); #1;
        chk("t3_same_cycle_grant", 64'(i_ready), 64'b1000);
        wait_drain(20);

        // Remaining route corners; ptr=0 after port 3.
        send(0, mk(2, 0, 32'h4444_0000), D_SOUTH, 1'b1);
        send(2, mk(2, 2, 32'h4444_0002), D_LOCAL, 1'b1);
        wait_drain(20);

        // Reset mid-hold; ptr=3 so port 1 is granted and then discarded.
        @(posedge clk); #1 o_ready = 1'b0;
        send(1, mk(0, 0, 32'h5555_0001), D_WEST, 1'b0);
        @(negedge clk);
        @(negedge clk); #1;
        chk("t5_hold_vld", 64'(o_valid), 64'd1);
        chk("t5_hold_src", 64'(o_src),   64'd1);
        @(posedge clk); #1;
        rst     = 1'b1;
        o_ready = 1'b1;
        send(0, mk(3, 3, 32'h6666_0000), D_EAST,  1'b1);
        send(2, mk(2, 3, 32'h6666_0002), D_NORTH, 1'b1);
        @(negedge clk); #1;
        chk("t5_rst_i_ready", 64'(i_ready), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); #1;
        chk("t5_after_rst_vld", 64'(o_valid), 64'd0);
        chk("t5_after_rst_pkt", 64'(o_pkt),   64'd0);
        chk("t5_first_grant",   64'(i_ready), 64'b0001);
        wait_drain(20);

        // Stress: 3 packets per port, all requesting from ptr=0 -> strict 0,1,2,3 rotation.
        pulse_reset();
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < NP; p++) begin
                x = $urandom_range(0, 3);
                y = $urandom_range(0, 3);
                send(p, mk(x, y, $urandom), exp_dir(x, y), 1'b1);
            end
        end
        for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
            @(posedge clk); #1 o_ready = 1'($urandom_range(0, 1));
        end
        o_ready = 1'b1;
        chk("stress_left", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        left = 0;
        for (int p = 0; p < NP; p++) left += pq[p].size();
        chk("stress_ports_drained", 64'(left), 64'd0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

endmodule
